rio_port: RTL and testbench
===========================

// Module: rio_port
// PURPOSE
//   Device-side end of the RIO register (r7) path. Turns CPU writes to RIO into a buffered byte stream
//   toward an external device, and supplies the byte the CPU reads from RIO out of a buffered stream
//   from that device. It owns what the register file's `in` returns on an RIO read and consumes RIO writes.
//   Sits between the core and one off-core byte device; one instance per core.
// PARAMETERS
//   DEPTH   4   entries in each of the TX and RX FIFOs; power of two, >= 2
//   WIDTH   8   data word width; matches the core word
// PORTS
//   clk           in   1            single clock, all state on posedge
//   reset         in   1            asynchronous, active-high; clears all state
//   cpu_wr        in   1            CPU writes RIO this cycle (write_enable && dst==RIO)
//   cpu_wdata     in   WIDTH        byte written by the CPU
//   cpu_rd        in   1            CPU consumes RIO this cycle (instruction sources RIO)
//   cpu_rdata     out  WIDTH        head of RX FIFO; 0x00 when RX empty
//   tx_data       out  WIDTH        head of TX FIFO toward device
//   tx_valid      out  1            TX FIFO non-empty
//   tx_ready      in   1            device accepts tx_data
//   rx_data       in   WIDTH        byte from device
//   rx_valid      in   1            device offers rx_data
//   rx_ready      out  1            RX FIFO not full
//   tx_count      out  $clog2(DEPTH)+1  TX occupancy
//   rx_count      out  $clog2(DEPTH)+1  RX occupancy
//   tx_overflow   out  1            sticky: cpu_wr dropped because TX full
//   rx_underflow  out  1            sticky: cpu_rd with RX empty
//   flag_clr      in   1            clears both sticky flags
// BEHAVIOUR
//   - Reset (async assert, sync release): pointers, counts, flags = 0; tx_valid=0, tx_data=0x00,
//     cpu_rdata=0x00, rx_ready=1 (RX empty). Storage contents need not clear; outputs gate on empty.
//   - Handshakes: transfer on tx_valid&&tx_ready (TX pop), rx_valid&&rx_ready (RX push).
//     tx_valid never drops without a transfer; tx_data stable while tx_valid&&!tx_ready.
//   - Latency: cpu_wr at cycle N -> tx_valid/tx_data at N+1 (no fall-through). RX push at N ->
//     cpu_rdata/rx_count updated at N+1. cpu_rdata, tx_data are show-ahead heads (no read latency).
//   - cpu_rd with RX non-empty pops the head; cpu_rdata shows next entry (or 0x00) at N+1.
//   - cpu_rd with RX empty: no pop, cpu_rdata=0x00, rx_underflow<=1. Same-cycle RX push still accepted.
//   - cpu_wr with TX full and no same-cycle TX pop: byte dropped, tx_overflow<=1, state unchanged.
//     TX full with same-cycle pop: write accepted, count stays DEPTH.
//   - RX full: rx_ready=0, no push. Full with same-cycle cpu_rd: still rx_ready=0 (ready is
//     combinational on count only, no ready->pop path).
//   - Simultaneous push+pop on a non-empty, non-full FIFO: count unchanged, both pointers advance.
//   - Pointers are log2(DEPTH) bits and wrap modulo DEPTH; count is separate and saturates by
//     construction at 0..DEPTH.
//   - flag_clr wins over a same-cycle set event (flag reads 0 next cycle).
//   - Reset mid-transfer: in-flight bytes are discarded; device must re-offer.
// STRUCTURE
//   - prelude_pkg: localparam RIO_ADDR = 3'b111; typedef logic [7:0] word_t. Core decode uses RIO_ADDR
//     to form cpu_wr/cpu_rd.
//   - Sub-module rio_fifo (DEPTH, WIDTH): push/pop/full/empty/count/head, pop-when-empty ignored,
//     push-when-full accepted only with same-cycle pop. Instantiated twice (tx_fifo, rx_fifo).
//   - rio_port top: handshake gating, underflow/overflow flags, 0x00 masking of cpu_rdata.
// TESTING
//   1. Reset then idle: tx_valid=0, rx_ready=1, cpu_rdata=0x00, counts=0, flags=0.
//   2. cpu_wr 0x11,0x22,0x33 with tx_ready=0 -> tx_count=3, tx_data=0x11; raise tx_ready ->
//      0x11,0x22,0x33 out in order on consecutive cycles, then tx_valid=0.
//   3. Device pushes 0xA1..0xA4 (DEPTH=4) -> rx_ready=0 after 4th; cpu_rd x4 returns
//      0xA1..0xA4 in order; rx_ready=1 again after first pop.
//   4. TX full, cpu_wr 0x55 with tx_ready=0 -> dropped, tx_overflow=1; repeat with tx_ready=1 ->
//      accepted, tx_count stays 4; flag_clr -> tx_overflow=0.
//   5. RX empty, cpu_rd with rx_valid=1 rx_data=0x7E same cycle -> cpu_rdata=0x00, rx_underflow=1,
//      next cycle cpu_rdata=0x7E, rx_count=1.
//   6. Assert reset async mid-stream (TX 2 entries, RX 3) -> all outputs at reset values
//      immediately, before next clk edge.

Source files
------------

// File: rtl/prelude_pkg.sv
// Shared definitions for the core's register path and the RIO device port.
package prelude_pkg;

  localparam logic [2:0] RIO_ADDR = 3'b111;

  typedef logic [7:0] word_t;

endpackage

// File: rtl/rio_fifo.sv
// Synchronous FIFO with a show-ahead head. A pop when empty is ignored.
// A push when full is taken only if a pop happens in the same cycle.
module rio_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_eff, pop_eff;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    pop_eff  = pop && !empty;
    push_eff = push && (!full || pop_eff);
    wr_ptr_d = push_eff ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_eff  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push_eff, pop_eff})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never reset; consumers gate the head on empty.
  always_ff @(posedge clk) begin
    if (push_eff) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/rio_port.sv
// Device-side end of the RIO register: CPU writes feed a TX FIFO toward the
// device, device bytes fill an RX FIFO that the CPU reads from.
module rio_port
  import prelude_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = $bits(word_t)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cpu_wr,
  input  logic [WIDTH-1:0]       cpu_wdata,
  input  logic                   cpu_rd,
  output logic [WIDTH-1:0]       cpu_rdata,
  output logic [WIDTH-1:0]       tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  input  logic [WIDTH-1:0]       rx_data,
  input  logic                   rx_valid,
  output logic                   rx_ready,
  output logic [$clog2(DEPTH):0] tx_count,
  output logic [$clog2(DEPTH):0] rx_count,
  output logic                   tx_overflow,
  output logic                   rx_underflow,
  input  logic                   flag_clr
);

  // Handshakes: a byte moves on the cycle valid && ready are both high.
  // tx_valid holds until accepted; rx_ready depends on RX occupancy only.

  logic             tx_full, tx_empty, rx_full, rx_empty;
  logic [WIDTH-1:0] tx_head, rx_head;
  logic             tx_overflow_q, tx_overflow_d;
  logic             rx_underflow_q, rx_underflow_d;

  rio_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (cpu_wr),
    .push_data (cpu_wdata),
    .pop       (tx_ready),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count),
    .head      (tx_head)
  );

  rio_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) rx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rx_valid && rx_ready),
    .push_data (rx_data),
    .pop       (cpu_rd),
    .full      (rx_full),
    .empty     (rx_empty),
    .count     (rx_count),
    .head      (rx_head)
  );

  assign tx_valid     = !tx_empty;
  assign tx_data      = tx_empty ? '0 : tx_head;
  assign rx_ready     = !rx_full;
  assign cpu_rdata    = rx_empty ? '0 : rx_head;
  assign tx_overflow  = tx_overflow_q;
  assign rx_underflow = rx_underflow_q;

  // A full TX FIFO is non-empty, so tx_ready alone means a pop makes room.
  always_comb begin
    tx_overflow_d  = tx_overflow_q;
    rx_underflow_d = rx_underflow_q;
    if (cpu_wr && tx_full && !tx_ready) tx_overflow_d = 1'b1;
    if (cpu_rd && rx_empty)             rx_underflow_d = 1'b1;
    if (flag_clr) begin
      tx_overflow_d  = 1'b0;
      rx_underflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_overflow_q  <= 1'b0;
      rx_underflow_q <= 1'b0;
    end else begin
      tx_overflow_q  <= tx_overflow_d;
      rx_underflow_q <= rx_underflow_d;
    end
  end

endmodule

// File: tb/tb_rio_port.sv
// Directed bench for rio_port: expected TX bytes and CPU read bytes are
// queued at stimulus time and popped by a monitor when the DUT presents them.
module tb_rio_port;

  localparam int DEPTH = 4;
  localparam int WIDTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             cpu_wr;
  logic [WIDTH-1:0] cpu_wdata;
  logic             cpu_rd;
  logic [WIDTH-1:0] cpu_rdata;
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             rx_ready;
  logic [CW-1:0]    tx_count;
  logic [CW-1:0]    rx_count;
  logic             tx_overflow;
  logic             rx_underflow;
  logic             flag_clr;

  logic [WIDTH-1:0] tx_exp_q[$];
  logic [WIDTH-1:0] rd_exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  rio_port #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_wr       (cpu_wr),
    .cpu_wdata    (cpu_wdata),
    .cpu_rd       (cpu_rd),
    .cpu_rdata    (cpu_rdata),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .tx_count     (tx_count),
    .rx_count     (rx_count),
    .tx_overflow  (tx_overflow),
    .rx_underflow (rx_underflow),
    .flag_clr     (flag_clr)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_tx_valid"},     32'(tx_valid),     32'h0);
    check({tag, "_tx_data"},      32'(tx_data),      32'h0);
    check({tag, "_rx_ready"},     32'(rx_ready),     32'h1);
    check({tag, "_cpu_rdata"},    32'(cpu_rdata),    32'h0);
    check({tag, "_tx_count"},     32'(tx_count),     32'h0);
    check({tag, "_rx_count"},     32'(rx_count),     32'h0);
    check({tag, "_tx_overflow"},  32'(tx_overflow),  32'h0);
    check({tag, "_rx_underflow"}, 32'(rx_underflow), 32'h0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!reset) begin
      if (tx_valid && tx_ready) begin
        if (tx_exp_q.size() == 0) check("tx_unexpected", 32'(tx_data), 32'hFFFF_FFFF);
        else check("tx_stream", 32'(tx_data), 32'(tx_exp_q.pop_front()));
      end
      if (cpu_rd) begin
        if (rd_exp_q.size() == 0) check("rd_unexpected", 32'(cpu_rdata), 32'hFFFF_FFFF);
        else check("rd_stream", 32'(cpu_rdata), 32'(rd_exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    cpu_wr = 1'b0; cpu_wdata = '0; cpu_rd = 1'b0;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0; flag_clr = 1'b0;
  endtask

  task automatic cpu_write(input logic [WIDTH-1:0] d, input bit expect_out);
    cpu_wr = 1'b1;
    cpu_wdata = d;
    if (expect_out) tx_exp_q.push_back(d);
  endtask

  task automatic cpu_read(input logic [WIDTH-1:0] exp);
    cpu_rd = 1'b1;
    rd_exp_q.push_back(exp);
  endtask

  task automatic dev_push(input logic [WIDTH-1:0] d);
    rx_valid = 1'b1;
    rx_data = d;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [WIDTH-1:0] rx_vec [4];
    rx_vec = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    drive_idle();
    reset = 1'b1;
    cyc(); cyc();
    reset = 1'b0;
    cyc();

    // 1. reset then idle
    check_idle("reset");

    // 2. three writes held, then drained in order
    cpu_write(8'h11, 1'b1); cyc();
    check("wr_latency_tx_count", 32'(tx_count), 32'd1);
    check("wr_latency_tx_data",  32'(tx_data),  32'h11);
    cpu_write(8'h22, 1'b1); cyc();
    cpu_write(8'h33, 1'b1); cyc();
    cpu_wr = 1'b0;
    check("tx_count_3", 32'(tx_count), 32'd3);
    check("tx_head_hold", 32'(tx_data), 32'h11);
    cyc();
    check("tx_data_stable", 32'(tx_data), 32'h11);
    tx_ready = 1'b1;
    cyc(); cyc(); cyc();
    check("tx_drained_valid", 32'(tx_valid), 32'h0);
    check("tx_drained_count", 32'(tx_count), 32'd0);
    tx_ready = 1'b0;

    // 3. fill RX, offer one more while full and reading, then read out
    foreach (rx_vec[i]) begin
      dev_push(rx_vec[i]);
      cyc();
    end
    check("rx_count_full", 32'(rx_count), 32'd4);
    dev_push(8'hA5);
    cpu_read(8'hA1);
    check("rx_ready_full_with_rd", 32'(rx_ready), 32'h0);
    cyc();
    rx_valid = 1'b0;
    check("rx_count_after_pop", 32'(rx_count), 32'd3);
    check("rx_ready_after_pop", 32'(rx_ready), 32'h1);
    cpu_read(8'hA2); cyc();
    cpu_read(8'hA3); cyc();
    cpu_read(8'hA4); cyc();
    cpu_rd = 1'b0;
    check("rx_empty_count", 32'(rx_count), 32'd0);
    check("rx_empty_rdata", 32'(cpu_rdata), 32'h0);
    check("rx_no_underflow", 32'(rx_underflow), 32'h0);

    // 4. TX overflow, write-while-full-with-pop, flag clear precedence
    for (int i = 1; i <= DEPTH; i++) begin
      cpu_write(8'(i), 1'b1);
      cyc();
    end
    check("tx_full_count", 32'(tx_count), 32'd4);
    cpu_write(8'h55, 1'b0); cyc();
    cpu_wr = 1'b0;
    check("tx_overflow_set", 32'(tx_overflow), 32'h1);
    check("tx_drop_count", 32'(tx_count), 32'd4);
    check("tx_drop_head", 32'(tx_data), 32'h01);
    cpu_write(8'h55, 1'b1);
    tx_ready = 1'b1;
    cyc();
    cpu_wr = 1'b0; tx_ready = 1'b0;
    check("tx_full_pop_count", 32'(tx_count), 32'd4);
    check("tx_overflow_sticky", 32'(tx_overflow), 32'h1);
    flag_clr = 1'b1; cyc();
    flag_clr = 1'b0;
    check("tx_overflow_cleared", 32'(tx_overflow), 32'h0);
    cpu_write(8'h66, 1'b0);
    flag_clr = 1'b1;
    cyc();
    cpu_wr = 1'b0; flag_clr = 1'b0;
    check("flag_clr_wins", 32'(tx_overflow), 32'h0);
    check("flag_clr_count", 32'(tx_count), 32'd4);
    tx_ready = 1'b1;
    cyc(); cyc(); cyc(); cyc();
    tx_ready = 1'b0;
    check("tx_wrap_drained", 32'(tx_valid), 32'h0);

    // 5. read from empty RX while device pushes
    cpu_read(8'h00);
    dev_push(8'h7E);
    cyc();
    cpu_rd = 1'b0; rx_valid = 1'b0;
    check("rx_underflow_set", 32'(rx_underflow), 32'h1);
    check("rx_push_during_underflow", 32'(cpu_rdata), 32'h7E);
    check("rx_count_1", 32'(rx_count), 32'd1);

    // 6. async reset mid-stream: TX 2 entries, RX 3 entries
    cpu_write(8'hC1, 1'b0); dev_push(8'hB1); cyc();
    cpu_write(8'hC2, 1'b0); dev_push(8'hB2); cyc();
    cpu_wr = 1'b0; rx_valid = 1'b0;
    check("pre_reset_tx_count", 32'(tx_count), 32'd2);
    check("pre_reset_rx_count", 32'(rx_count), 32'd3);
    #2;
    reset = 1'b1;
    #1;
    check_idle("async_reset");
    cyc();
    reset = 1'b0;
    cyc();
    check_idle("post_reset");

    check("tx_queue_drained", 32'(tx_exp_q.size()), 32'd0);
    check("rd_queue_drained", 32'(rd_exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
